wb_master_initiator: RTL and testbench
======================================

// Module: wb_master_initiator
// PURPOSE
//  Wishbone B4 classic single-transfer bus master, the initiator counterpart to the testbench slave interface.
//  Converts one valid/ready command into one CYC/STB cycle and returns a response (data, tag, status) on a
//  valid/ready channel. Handles ACK/ERR/RTY, bounded retry with back-off and an optional watchdog timeout.
//  Sits between a DMA/CPU-style requester and the Wishbone interconnect; one outstanding transfer at a time.
// PARAMETERS
//  ADR_W           64   address width (ADR_O)
//  DAT_W           64   data width (DAT_O/DAT_I)
//  SEL_W           DAT_W/8  byte-select width
//  TAG_W           16   width of TGA/TGC/TGD tags
//  MAX_RETRY       3    re-issues allowed after RTY_I (total attempts = MAX_RETRY+1)
//  RETRY_GAP       4    idle cycles (CYC_O low) between a RTY_I and the re-issue; >=1
//  TIMEOUT_CYCLES  256  bus cycles without ACK/ERR/RTY before abort (WB_MASTER_TIMEOUT_EN only)
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      reset: synchronous, active-high
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      command accepted when valid&ready
//  cmd_we      in   1      1=write, 0=read
//  cmd_adr     in   ADR_W  address; cmd_dat in DAT_W write data; cmd_sel in SEL_W byte enables
//  cmd_lock    in   1      drive LOCK_O for this cycle
//  cmd_tga/cmd_tgc/cmd_tgd  in  TAG_W  address/cycle/data tags
//  rsp_valid   out  1      response present; rsp_ready in 1 response consumed
//  rsp_dat     out  DAT_W  read data (0 for writes); rsp_tgd out TAG_W captured TGD_I
//  rsp_status  out  2      0 OK, 1 ERR, 2 RETRY_EXHAUSTED, 3 TIMEOUT
//  CYC_O STB_O WE_O LOCK_O  out 1; ADR_O out ADR_W; DAT_O out DAT_W; SEL_O out SEL_W; TGA_O TGC_O TGD_O out TAG_W
//  ACK_I ERR_I RTY_I  in 1; DAT_I in DAT_W; TGD_I in TAG_W
// BEHAVIOUR
//  - All outputs registered. Reset (sync, active-high): every output 0, state IDLE, counters 0; dominates all.
//  - FSM IDLE -> BUS -> {RESP | BACKOFF}; BACKOFF -> BUS; RESP -> IDLE.
//  - IDLE: cmd_ready=1 (only here). On valid&ready at edge N: latch command, CYC_O=STB_O=1 from edge N.
//    WE_O/ADR_O/SEL_O/LOCK_O/tags from latch; DAT_O=cmd_dat on write, 0 on read.
//  - BUS: all bus outputs held stable until a termination is sampled. Priority ERR_I > RTY_I > ACK_I.
//    ACK_I: capture DAT_I (reads) and TGD_I, drop CYC/STB at same edge, -> RESP status 0.
//    ERR_I: drop CYC/STB, -> RESP status 1, rsp_dat=0.
//    RTY_I: if retry_cnt<MAX_RETRY: drop CYC/STB, retry_cnt++, -> BACKOFF; else drop, -> RESP status 2.
//  - BACKOFF: CYC_O=STB_O=0 for exactly RETRY_GAP cycles, then re-assert with identical latched command.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake -> IDLE, retry_cnt=0.
//    cmd_ready is not asserted in the same cycle as rsp_valid (min 3-cycle cmd-to-cmd with zero-wait ACK).
//  - Latency: zero-wait slave -> ACK sampled at edge N+1, rsp_valid high from edge N+1.
//  - Reset mid-cycle: CYC/STB low after the reset edge, in-flight command discarded, no response.
//  - Terminations outside BUS are ignored.
// CONFIGURATION
//  WB_MASTER_TIMEOUT_EN defined: watchdog counts BUS cycles from STB_O rise; at TIMEOUT_CYCLES with no
//    termination: drop CYC/STB, -> RESP status 3; counter clears on every (re-)issue.
//  Not defined: no counter logic, BUS waits indefinitely, status 3 never produced.
// STRUCTURE
//  wb_master_pkg: wb_rsp_status_e (OK/ERR/RETRY_EXH/TIMEOUT), wb_mst_state_e, default width constants.
//  Sub-module wb_master_timer: shared down-counter (load/expire) for back-off gap and watchdog.
// TESTING
//  1 Write adr 0x1000 dat 0xDEADBEEF_CAFEF00D sel 0xFF, ACK after 2 waits -> WE_O=1, STB high 3 cycles, status 0.
//  2 Read adr 0x2000, ACK with DAT_I 0x0123456789ABCDEF TGD_I 0x00A5 -> rsp_dat/rsp_tgd match, DAT_O=0, status 0.
//  3 RTY,RTY,ACK -> two 4-cycle CYC-low gaps, 3 attempts, status 0; RTY x4 -> 4 attempts, status 2.
//  4 ERR_I and ACK_I same cycle -> status 1, rsp_dat=0; RTY_I+ACK_I same cycle -> treated as retry.
//  5 rsp_ready low 10 cycles -> rsp_valid/rsp_* held, cmd_ready=0, CYC_O=0 throughout.
//  6 Silent slave: macro on -> CYC drop after 256 cycles, status 3; macro off -> CYC held; rst mid-BUS -> no rsp.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and default widths for the Wishbone B4 classic single-transfer master.
package wb_master_pkg;

  localparam int unsigned WB_ADR_W          = 64;
  localparam int unsigned WB_DAT_W          = 64;
  localparam int unsigned WB_TAG_W          = 16;
  localparam int unsigned WB_MAX_RETRY      = 3;
  localparam int unsigned WB_RETRY_GAP      = 4;
  localparam int unsigned WB_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    RSP_OK        = 2'd0,
    RSP_ERR       = 2'd1,
    RSP_RETRY_EXH = 2'd2,
    RSP_TIMEOUT   = 2'd3
  } wb_rsp_status_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } wb_mst_state_e;

  // Bits needed to hold counts 0 .. n-1 (at least one bit).
  function automatic int unsigned wb_cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_master_timer.sv
// Loadable saturating down-counter; expired_c is high while the count sits at zero.
module wb_master_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/wb_master_initiator.sv
// Wishbone B4 classic single-transfer master: valid/ready command in, CYC/STB cycle, response out.
// Optional bus watchdog is compiled in when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_initiator
  import wb_master_pkg::*;
#(
  parameter int unsigned ADR_W          = WB_ADR_W,
  parameter int unsigned DAT_W          = WB_DAT_W,
  parameter int unsigned SEL_W          = DAT_W / 8,
  parameter int unsigned TAG_W          = WB_TAG_W,
  parameter int unsigned MAX_RETRY      = WB_MAX_RETRY,
  parameter int unsigned RETRY_GAP      = WB_RETRY_GAP,
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_lock,
  input  logic [TAG_W-1:0] cmd_tga,
  input  logic [TAG_W-1:0] cmd_tgc,
  input  logic [TAG_W-1:0] cmd_tgd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic [TAG_W-1:0] rsp_tgd,
  output logic [1:0]       rsp_status,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  output logic             LOCK_O,
  output logic [ADR_W-1:0] ADR_O,
  output logic [DAT_W-1:0] DAT_O,
  output logic [SEL_W-1:0] SEL_O,
  output logic [TAG_W-1:0] TGA_O,
  output logic [TAG_W-1:0] TGC_O,
  output logic [TAG_W-1:0] TGD_O,
  input  logic             ACK_I,
  input  logic             ERR_I,
  input  logic             RTY_I,
  input  logic [DAT_W-1:0] DAT_I,
  input  logic [TAG_W-1:0] TGD_I
);

  localparam int unsigned TMR_MAX = (RETRY_GAP > TIMEOUT_CYCLES) ? RETRY_GAP : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = wb_cnt_w(TMR_MAX);
  localparam int unsigned RTR_W   = wb_cnt_w(MAX_RETRY + 1);

  wb_mst_state_e    state_q, state_d;
  logic [RTR_W-1:0] retry_q, retry_d;
  logic             lock_q, lock_l_d;
  logic             cyc_d, stb_d, we_d, lock_d, cmd_ready_d, rsp_valid_d;
  logic [ADR_W-1:0] adr_d;
  logic [DAT_W-1:0] dato_d, rsp_dat_d;
  logic [SEL_W-1:0] sel_d;
  logic [TAG_W-1:0] tga_d, tgc_d, tgd_d, rsp_tgd_d;
  logic [1:0]       rsp_status_d;
  logic             tmr_load, tmr_dec, tmr_expired_c;
  logic [TMR_W-1:0] tmr_val;

  // One counter serves both the back-off gap and the bus watchdog; they never overlap.
  wb_master_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .dec       (tmr_dec),
    .expired_c (tmr_expired_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    lock_l_d     = lock_q;
    cyc_d        = CYC_O;
    stb_d        = STB_O;
    we_d         = WE_O;
    lock_d       = LOCK_O;
    adr_d        = ADR_O;
    dato_d       = DAT_O;
    sel_d        = SEL_O;
    tga_d        = TGA_O;
    tgc_d        = TGC_O;
    tgd_d        = TGD_O;
    cmd_ready_d  = 1'b0;
    rsp_valid_d  = rsp_valid;
    rsp_dat_d    = rsp_dat;
    rsp_tgd_d    = rsp_tgd;
    rsp_status_d = rsp_status;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_val      = '0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          state_d     = ST_BUS;
          retry_d     = '0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = cmd_we;
          lock_d      = cmd_lock;
          lock_l_d    = cmd_lock;
          adr_d       = cmd_adr;
          dato_d      = cmd_we ? cmd_dat : '0;
          sel_d       = cmd_sel;
          tga_d       = cmd_tga;
          tgc_d       = cmd_tgc;
          tgd_d       = cmd_tgd;
`ifdef WB_MASTER_TIMEOUT_EN
          tmr_load    = 1'b1;
          tmr_val     = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end

      ST_BUS: begin
`ifdef WB_MASTER_TIMEOUT_EN
        tmr_dec = 1'b1;
`endif
        if (ERR_I) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          lock_d       = 1'b0;
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_ERR;
          rsp_dat_d    = '0;
          rsp_tgd_d    = '0;
        end else if (RTY_I) begin
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          lock_d = 1'b0;
          if (retry_q < RTR_W'(MAX_RETRY)) begin
            retry_d  = retry_q + RTR_W'(1);
            state_d  = ST_BACKOFF;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(RETRY_GAP - 1);
          end else begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_RETRY_EXH;
            rsp_dat_d    = '0;
            rsp_tgd_d    = '0;
          end
        end else if (ACK_I) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          lock_d       = 1'b0;
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_OK;
          rsp_dat_d    = WE_O ? '0 : DAT_I;
          rsp_tgd_d    = TGD_I;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tmr_expired_c) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          lock_d       = 1'b0;
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_TIMEOUT;
          rsp_dat_d    = '0;
          rsp_tgd_d    = '0;
        end
`endif
      end

      ST_BACKOFF: begin
        if (tmr_expired_c) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          lock_d  = lock_q;
`ifdef WB_MASTER_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          retry_d     = '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      lock_q     <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_tgd    <= '0;
      rsp_status <= '0;
      CYC_O      <= 1'b0;
      STB_O      <= 1'b0;
      WE_O       <= 1'b0;
      LOCK_O     <= 1'b0;
      ADR_O      <= '0;
      DAT_O      <= '0;
      SEL_O      <= '0;
      TGA_O      <= '0;
      TGC_O      <= '0;
      TGD_O      <= '0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      lock_q     <= lock_l_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_dat    <= rsp_dat_d;
      rsp_tgd    <= rsp_tgd_d;
      rsp_status <= rsp_status_d;
      CYC_O      <= cyc_d;
      STB_O      <= stb_d;
      WE_O       <= we_d;
      LOCK_O     <= lock_d;
      ADR_O      <= adr_d;
      DAT_O      <= dato_d;
      SEL_O      <= sel_d;
      TGA_O      <= tga_d;
      TGC_O      <= tgc_d;
      TGD_O      <= tgd_d;
    end
  end

endmodule

// File: tb/tb_wb_master_initiator.sv
// Self-checking bench for wb_master_initiator: scripted Wishbone slave plus a transaction-level model.
`timescale 1ns/1ps
module tb_wb_master_initiator;

  localparam int unsigned ADR_W = 64, DAT_W = 64, SEL_W = 8, TAG_W = 16;
  localparam int unsigned MAX_RETRY = 3, RETRY_GAP = 4, TIMEOUT_CYCLES = 256;
  localparam int T_ACK = 0, T_ERR = 1, T_RTY = 2, T_ERRACK = 3, T_RTYACK = 4, T_SILENT = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_we, cmd_lock;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_dat;
  logic [SEL_W-1:0] cmd_sel;
  logic [TAG_W-1:0] cmd_tga, cmd_tgc, cmd_tgd;
  logic             rsp_valid, rsp_ready;
  logic [DAT_W-1:0] rsp_dat;
  logic [TAG_W-1:0] rsp_tgd;
  logic [1:0]       rsp_status;
  logic             CYC_O, STB_O, WE_O, LOCK_O;
  logic [ADR_W-1:0] ADR_O;
  logic [DAT_W-1:0] DAT_O;
  logic [SEL_W-1:0] SEL_O;
  logic [TAG_W-1:0] TGA_O, TGC_O, TGD_O;
  logic             ACK_I, ERR_I, RTY_I;
  logic [DAT_W-1:0] DAT_I;
  logic [TAG_W-1:0] TGD_I;

  wb_master_initiator #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TAG_W(TAG_W),
    .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_lock(cmd_lock),
    .cmd_tga(cmd_tga), .cmd_tgc(cmd_tgc), .cmd_tgd(cmd_tgd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_tgd(rsp_tgd),
    .rsp_status(rsp_status),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .LOCK_O(LOCK_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .SEL_O(SEL_O), .TGA_O(TGA_O), .TGC_O(TGC_O), .TGD_O(TGD_O),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .DAT_I(DAT_I), .TGD_I(TGD_I)
  );

  always #5 clk = ~clk;

  int cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave script: per attempt, wait states and the termination to give.
  int plan_wait [8];
  int plan_term [8];
  logic [DAT_W-1:0] slv_dat;
  logic [TAG_W-1:0] slv_tgd;

  // Observations from the last transaction.
  int               obs_att, obs_bus_bad, obs_hold_bad, acc_cycle;
  int               obs_stb_len [8];
  int               obs_gap [8];
  logic             obs_rsp, obs_after_valid, obs_after_ready;
  logic [1:0]       obs_status;
  logic [DAT_W-1:0] obs_dat;
  logic [TAG_W-1:0] obs_tgd;
  logic             rec_we, rec_lock;
  logic [ADR_W-1:0] rec_adr;
  logic [DAT_W-1:0] rec_dato;
  logic [SEL_W-1:0] rec_sel;
  logic [TAG_W-1:0] rec_tga, rec_tgc, rec_tgd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_lock = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    cmd_tga = '0; cmd_tgc = '0; cmd_tgd = '0; rsp_ready = 1'b0;
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0; DAT_I = '0; TGD_I = '0;
  endtask

  task automatic set_plan1(input int w, input int t);
    for (int i = 0; i < 8; i++) begin plan_wait[i] = 0; plan_term[i] = T_ACK; end
    plan_wait[0] = w; plan_term[0] = t;
  endtask

  // Issue one command, play the slave script, collect the response and release it after rsp_hold cycles.
  task automatic do_txn(input logic we, input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] dat,
                        input logic [SEL_W-1:0] sel, input logic lock, input logic [TAG_W-1:0] tga,
                        input logic [TAG_W-1:0] tgc, input logic [TAG_W-1:0] tgd,
                        input int rsp_hold, input int limit);
    int w, cnt, low, a;
    logic prev_stb;
    obs_att = 0; obs_bus_bad = 0; obs_hold_bad = 0; obs_rsp = 1'b0;
    obs_status = 2'bxx; obs_dat = 'x; obs_tgd = 'x; obs_after_valid = 1'bx; obs_after_ready = 1'bx;
    for (int i = 0; i < 8; i++) begin obs_stb_len[i] = 0; obs_gap[i] = 0; end
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin tick(); w++; end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_wait got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_lock = lock;
    cmd_tga = tga; cmd_tgc = tgc; cmd_tgd = tgd;
    tick();
    acc_cycle = cycle_no;
    cmd_valid = 1'b0;
    cmd_adr = {$urandom, $urandom}; cmd_dat = {$urandom, $urandom};
    prev_stb = 1'b0; cnt = 0; low = 0;
    for (int c = 0; c < limit; c++) begin
      if (rsp_valid === 1'b1) begin
        obs_rsp = 1'b1; obs_status = rsp_status; obs_dat = rsp_dat; obs_tgd = rsp_tgd;
        if (cmd_ready !== 1'b0 || CYC_O !== 1'b0 || STB_O !== 1'b0) obs_hold_bad++;
        break;
      end
      if (cmd_ready !== 1'b0) obs_bus_bad++;
      ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
      DAT_I = {$urandom, $urandom}; TGD_I = TAG_W'($urandom);
      if (STB_O === 1'b1) begin
        if (!prev_stb) begin
          if (obs_att < 8) obs_att++;
          cnt = 0;
          if (obs_att == 1) begin
            rec_we = WE_O; rec_adr = ADR_O; rec_dato = DAT_O; rec_sel = SEL_O; rec_lock = LOCK_O;
            rec_tga = TGA_O; rec_tgc = TGC_O; rec_tgd = TGD_O;
          end else begin
            obs_gap[obs_att-2] = low;
          end
        end
        if ({WE_O, LOCK_O, ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, TGD_O} !==
            {rec_we, rec_lock, rec_adr, rec_dato, rec_sel, rec_tga, rec_tgc, rec_tgd} || CYC_O !== 1'b1)
          obs_bus_bad++;
        cnt++;
        a = obs_att - 1;
        obs_stb_len[a] = cnt;
        if (plan_term[a] != T_SILENT && cnt - 1 >= plan_wait[a]) begin
          case (plan_term[a])
            T_ACK:    begin ACK_I = 1'b1; DAT_I = slv_dat; TGD_I = slv_tgd; end
            T_ERR:    ERR_I = 1'b1;
            T_RTY:    RTY_I = 1'b1;
            T_ERRACK: begin ERR_I = 1'b1; ACK_I = 1'b1; DAT_I = slv_dat; TGD_I = slv_tgd; end
            T_RTYACK: begin RTY_I = 1'b1; ACK_I = 1'b1; DAT_I = slv_dat; TGD_I = slv_tgd; end
            default:  ;
          endcase
        end
        low = 0;
      end else begin
        low++;
        ACK_I = 1'($urandom_range(0, 1));  // stray ACK while idle must be ignored
      end
      prev_stb = STB_O;
      tick();
    end
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
    if (obs_rsp) begin
      for (int h = 0; h < rsp_hold; h++) begin
        tick();
        if (rsp_valid !== 1'b1 || rsp_status !== obs_status || rsp_dat !== obs_dat ||
            rsp_tgd !== obs_tgd || cmd_ready !== 1'b0 || CYC_O !== 1'b0) obs_hold_bad++;
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      obs_after_valid = rsp_valid;
      obs_after_ready = cmd_ready;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({CYC_O, STB_O, WE_O, LOCK_O, cmd_ready, rsp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000000", {CYC_O, STB_O, WE_O, LOCK_O, cmd_ready, rsp_valid});
    end
    n_checks++;
    if ({ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, TGD_O, rsp_dat, rsp_tgd, rsp_status} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {ADR_O, DAT_O, rsp_dat});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    set_plan1(2, T_ACK);
    slv_dat = 64'h5555_AAAA_1234_5678; slv_tgd = 16'h0F0F;
    do_txn(1'b1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 16'h0011, 16'h0022, 16'h0033, 0, 50);
    n_checks++;
    if (obs_rsp !== 1'b1 || obs_status !== 2'd0) begin n_fail++; $display("FAIL wr_status got %0d want 0", obs_status); end
    n_checks++;
    if (rec_we !== 1'b1 || rec_adr !== 64'h1000 || rec_dato !== 64'hDEADBEEF_CAFEF00D || rec_sel !== 8'hFF)
      begin n_fail++; $display("FAIL wr_bus got we=%b adr=%h dat=%h want 1/1000/deadbeefcafef00d", rec_we, rec_adr, rec_dato); end
    n_checks++;
    if (rec_lock !== 1'b1 || {rec_tga, rec_tgc, rec_tgd} !== 48'h0011_0022_0033)
      begin n_fail++; $display("FAIL wr_tags got %h want 001100220033", {rec_tga, rec_tgc, rec_tgd}); end
    n_checks++;
    if (obs_stb_len[0] != 3 || obs_att != 1) begin n_fail++; $display("FAIL wr_stb_len got %0d want 3", obs_stb_len[0]); end
    n_checks++;
    if (obs_dat !== '0 || obs_bus_bad != 0) begin n_fail++; $display("FAIL wr_rsp_dat got %h bad=%0d want 0", obs_dat, obs_bus_bad); end
    n_checks++;
    if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1)
      begin n_fail++; $display("FAIL wr_handshake got v=%b r=%b want 0/1", obs_after_valid, obs_after_ready); end
  endtask

  task automatic test_read();
    set_plan1(0, T_ACK);
    slv_dat = 64'h0123456789ABCDEF; slv_tgd = 16'h00A5;
    do_txn(1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 16'h1, 16'h2, 16'h3, 0, 50);
    n_checks++;
    if (obs_dat !== 64'h0123456789ABCDEF || obs_tgd !== 16'h00A5)
      begin n_fail++; $display("FAIL rd_data got %h/%h want 0123456789abcdef/00a5", obs_dat, obs_tgd); end
    n_checks++;
    if (rec_dato !== '0 || rec_we !== 1'b0 || obs_status !== 2'd0 || obs_stb_len[0] != 1)
      begin n_fail++; $display("FAIL rd_bus got dato=%h st=%0d len=%0d want 0/0/1", rec_dato, obs_status, obs_stb_len[0]); end
  endtask

  task automatic test_retry();
    set_plan1(1, T_RTY);
    plan_term[1] = T_RTY; plan_wait[1] = 0; plan_term[2] = T_ACK; plan_wait[2] = 2;
    slv_dat = {$urandom, $urandom}; slv_tgd = 16'h7E57;
    do_txn(1'b0, 64'h3000, '0, 8'h01, 1'b0, '0, '0, '0, 0, 100);
    n_checks++;
    if (obs_att != 3 || obs_status !== 2'd0 || obs_dat !== slv_dat)
      begin n_fail++; $display("FAIL rty_ok got att=%0d st=%0d want 3/0", obs_att, obs_status); end
    n_checks++;
    if (obs_gap[0] != RETRY_GAP || obs_gap[1] != RETRY_GAP || obs_bus_bad != 0)
      begin n_fail++; $display("FAIL rty_gap got %0d,%0d bad=%0d want %0d", obs_gap[0], obs_gap[1], obs_bus_bad, RETRY_GAP); end
    set_plan1(0, T_RTY);
    for (int i = 1; i < 8; i++) plan_term[i] = T_RTY;
    do_txn(1'b1, 64'h3008, 64'h1, 8'h01, 1'b0, '0, '0, '0, 0, 100);
    n_checks++;
    if (obs_att != MAX_RETRY + 1 || obs_status !== 2'd2)
      begin n_fail++; $display("FAIL rty_exh got att=%0d st=%0d want %0d/2", obs_att, obs_status, MAX_RETRY + 1); end
  endtask

  task automatic test_priority();
    set_plan1(1, T_ERRACK);
    slv_dat = 64'hFEED_FACE_0000_0001; slv_tgd = 16'h1234;
    do_txn(1'b0, 64'h4000, '0, 8'hFF, 1'b0, '0, '0, '0, 0, 50);
    n_checks++;
    if (obs_status !== 2'd1 || obs_dat !== '0)
      begin n_fail++; $display("FAIL err_prio got st=%0d dat=%h want 1/0", obs_status, obs_dat); end
    set_plan1(0, T_RTYACK);
    plan_term[1] = T_ACK;
    do_txn(1'b0, 64'h4008, '0, 8'hFF, 1'b0, '0, '0, '0, 0, 50);
    n_checks++;
    if (obs_att != 2 || obs_status !== 2'd0 || obs_gap[0] != RETRY_GAP)
      begin n_fail++; $display("FAIL rty_prio got att=%0d st=%0d want 2/0", obs_att, obs_status); end
  endtask

  task automatic test_backpressure();
    set_plan1(0, T_ACK);
    slv_dat = 64'hA5A5_5A5A_0F0F_F0F0; slv_tgd = 16'hBEEF;
    do_txn(1'b0, 64'h5000, '0, 8'hFF, 1'b0, '0, '0, '0, 10, 50);
    n_checks++;
    if (obs_hold_bad != 0 || obs_dat !== slv_dat)
      begin n_fail++; $display("FAIL rsp_hold got bad=%0d dat=%h want 0/%h", obs_hold_bad, obs_dat, slv_dat); end
    n_checks++;
    if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1)
      begin n_fail++; $display("FAIL rsp_release got v=%b r=%b want 0/1", obs_after_valid, obs_after_ready); end
  endtask

  task automatic test_back_to_back();
    int first;
    set_plan1(0, T_ACK);
    slv_dat = 64'h1; slv_tgd = 16'h1;
    do_txn(1'b1, 64'h6000, 64'h11, 8'hFF, 1'b0, '0, '0, '0, 0, 50);
    first = acc_cycle;
    do_txn(1'b0, 64'h6008, 64'h22, 8'hFF, 1'b0, '0, '0, '0, 0, 50);
    n_checks++;
    if (acc_cycle - first != 3) begin n_fail++; $display("FAIL b2b_spacing got %0d want 3", acc_cycle - first); end
  endtask

  // Random commands and slave scripts against a transaction-level model.
  task automatic test_random();
    logic             we, lock;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [TAG_W-1:0] ta, tc, td;
    int exp_att, exp_st, bad;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1)); lock = 1'($urandom_range(0, 1));
      adr = {$urandom, $urandom}; dat = {$urandom, $urandom};
      ta = TAG_W'($urandom); tc = TAG_W'($urandom); td = TAG_W'($urandom);
      slv_dat = {$urandom, $urandom}; slv_tgd = TAG_W'($urandom);
      for (int i = 0; i < 8; i++) begin plan_wait[i] = $urandom_range(0, 3); plan_term[i] = $urandom_range(0, 4); end
      exp_att = 0; exp_st = 0;
      for (int i = 0; i < 8; i++) begin
        exp_att = i + 1;
        if (plan_term[i] == T_ERR || plan_term[i] == T_ERRACK) begin exp_st = 1; break; end
        if (plan_term[i] == T_RTY || plan_term[i] == T_RTYACK) begin
          if (i < int'(MAX_RETRY)) continue;
          exp_st = 2; break;
        end
        exp_st = 0; break;
      end
      do_txn(we, adr, dat, SEL_W'($urandom), lock, ta, tc, td, $urandom_range(0, 3), 200);
      n_checks++;
      if (obs_rsp !== 1'b1 || obs_status !== 2'(exp_st) || obs_att != exp_att)
        begin n_fail++; $display("FAIL rnd%0d_status got st=%0d att=%0d want %0d/%0d", n, obs_status, obs_att, exp_st, exp_att); end
      n_checks++;
      if (obs_dat !== ((exp_st == 0 && !we) ? slv_dat : '0) || (exp_st == 0 && obs_tgd !== slv_tgd))
        begin n_fail++; $display("FAIL rnd%0d_rsp got %h/%h", n, obs_dat, obs_tgd); end
      bad = obs_bus_bad + obs_hold_bad;
      for (int i = 0; i < exp_att; i++) begin
        if (obs_stb_len[i] != plan_wait[i] + 1) bad++;
        if (i < exp_att - 1 && obs_gap[i] != int'(RETRY_GAP)) bad++;
      end
      if ({rec_we, rec_lock, rec_adr, rec_dato, rec_tga, rec_tgc, rec_tgd} !==
          {we, lock, adr, (we ? dat : 64'h0), ta, tc, td}) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_bus got %0d errors want 0", n, bad); end
    end
  endtask

  task automatic test_silent();
    set_plan1(0, T_SILENT);
`ifdef WB_MASTER_TIMEOUT_EN
    do_txn(1'b0, 64'h7000, '0, 8'hFF, 1'b0, '0, '0, '0, 0, 400);
    n_checks++;
    if (obs_status !== 2'd3 || obs_stb_len[0] != int'(TIMEOUT_CYCLES))
      begin n_fail++; $display("FAIL tmo got st=%0d len=%0d want 3/%0d", obs_status, obs_stb_len[0], TIMEOUT_CYCLES); end
    plan_wait[0] = 10; plan_term[0] = T_RTY; plan_term[1] = T_SILENT;
    do_txn(1'b0, 64'h7008, '0, 8'hFF, 1'b0, '0, '0, '0, 0, 400);
    n_checks++;
    if (obs_status !== 2'd3 || obs_att != 2 || obs_stb_len[1] != int'(TIMEOUT_CYCLES))
      begin n_fail++; $display("FAIL tmo_reissue got st=%0d len=%0d want 3/%0d", obs_status, obs_stb_len[1], TIMEOUT_CYCLES); end
`else
    do_txn(1'b0, 64'h7000, '0, 8'hFF, 1'b0, '0, '0, '0, 0, 300);
    n_checks++;
    if (obs_rsp !== 1'b0 || CYC_O !== 1'b1 || STB_O !== 1'b1)
      begin n_fail++; $display("FAIL no_tmo got rsp=%b cyc=%b want 0/1", obs_rsp, CYC_O); end
    rst = 1'b1; tick(); rst = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_bus();
    int seen;
    set_plan1(0, T_SILENT);
    while (cmd_ready !== 1'b1 && seen < 20) begin tick(); seen++; end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 64'h8000; cmd_dat = 64'h99;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (CYC_O !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got cyc=%b want 1", CYC_O); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({CYC_O, STB_O, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL rstmid_drop got %b want 000", {CYC_O, STB_O, rsp_valid}); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      ACK_I = 1'b1;
      tick();
      if (rsp_valid !== 1'b0 || CYC_O !== 1'b0) seen++;
    end
    ACK_I = 1'b0;
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rstmid_norsp got %0d bad cycles want 0", seen); end
    set_plan1(1, T_ACK);
    slv_dat = 64'hC0FFEE; slv_tgd = 16'h4242;
    do_txn(1'b0, 64'h8008, '0, 8'hFF, 1'b0, '0, '0, '0, 0, 50);
    n_checks++;
    if (obs_status !== 2'd0 || obs_dat !== 64'hC0FFEE || obs_att != 1)
      begin n_fail++; $display("FAIL rstmid_after got st=%0d dat=%h want 0/c0ffee", obs_status, obs_dat); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_retry();
    test_priority();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_silent();
    test_reset_mid_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
